qam_spc: RTL and testbench
==========================

// Module: qam_spc
// PURPOSE
//  Serial-to-parallel converter at the front of the QAM transmitter mapper.
//  - Collects BPS consecutive serial bits from Din into one symbol word on OUT.
//  - Default BPS=2 (QPSK/4-QAM), giving one 2-bit symbol per two enabled clocks.
//  - OUT feeds the constellation mapper; it is registered and holds between updates.
// PARAMETERS
//  BPS        2   bits per symbol; OUT width; legal range 2..8
//  MSB_FIRST  1   1: first received bit lands in OUT[BPS-1]; 0: first bit lands in OUT[0]
// PORTS
//  clk   in   1    single system clock; all state updates on rising edge
//  rst   in   1    reset, asynchronous, active-low; clears all state
//  en    in   1    bit-valid; Din is consumed on every rising clk edge with en=1
//  Din   in   1    serial data bit
//  OUT   out  BPS  parallel symbol, registered
// BEHAVIOUR
//  - Reset (rst=0, async): OUT=0, bit counter cnt=0, shift register sr=0.
//    Any partially collected symbol is discarded.
//  - State:
//    - sr[BPS-2:0] holds the bits received so far.
//    - cnt counts 0..BPS-1 and wraps.
//  - Rising edge with en=1 and cnt<BPS-1: shift Din into sr, then cnt++.
//    OUT is unchanged.
//  - Rising edge with en=1 and cnt==BPS-1: the symbol completes.
//    - MSB_FIRST=1: OUT <= {sr, Din}.
//    - MSB_FIRST=0: OUT <= bit-reversed order of the same word.
//    - cnt <= 0; sr is don't-care afterwards and is overwritten by later bits.
//  - Rising edge with en=0: everything holds, including cnt, sr and OUT.
//    A symbol may therefore straddle gaps in en.
//  - Latency: OUT shows the new symbol right after the edge that samples the
//    symbol's last bit. It holds for at least BPS enabled cycles.
//  - Continuous en: OUT updates every BPS cycles; symbol k is bits [k*BPS .. k*BPS+BPS-1].
//  - Din is sampled only when en=1; X on Din while en=0 must not propagate.
//  - Reset deassertion mid-stream: the first bit sampled afterwards is bit 0 of a new symbol.
//  - No output handshake: the downstream block samples OUT on the same cnt
//    phase, every BPS cycles.
// STRUCTURE
//  - Shared QAM package holds:
//    - QPSK_BPS=2 and the symbol word typedef (logic [BPS-1:0]);
//    - the MSB_FIRST convention constant, reused by the mapper.
//  - Single flat module, no sub-modules: counter, shift register and output register.
//  - A generate block selects the bit ordering from MSB_FIRST.
// TESTING
//  1. Reset: hold rst=0 for 10 cycles with random Din/en -> OUT=0 throughout.
//     Assert rst=0 asynchronously between edges -> OUT=0 immediately.
//  2. Stream: BPS=2, en=1, Din=1,0,0,1,1,1,0,0 -> OUT becomes 2'b10, 01, 11, 00.
//     Each value appears right after the 2nd, 4th, 6th and 8th edges and holds for 2 cycles.
//  3. Bulk: 1024 random bits, en=1 continuously -> 512 symbols.
//     Each equals {bit[2k], bit[2k+1]}; compare at every second edge; expect 512/512 matches.
//  4. en gaps: Din=1, then en=0 for 3 cycles with Din toggling, then Din=1 ->
//     OUT=2'b11 only after the 2nd enabled bit; OUT unchanged during the gap.
//  5. Mid-symbol reset: send 1 bit (1), pulse rst=0, then send 0,1 -> OUT=2'b01.
//     The stale bit is discarded.
//  6. Parameters: BPS=4, MSB_FIRST=0, Din=1,1,0,0 -> OUT=4'b0011 after the 4th edge.

Source files
------------

// File: rtl/qam_spc_pkg.sv
// Shared QAM transmitter definitions: default symbol width, symbol word type
// and the bit-ordering convention used by both the S/P converter and the mapper.
package qam_spc_pkg;

  localparam int QPSK_BPS = 2;

  typedef logic [QPSK_BPS-1:0] qpsk_sym_t;

  // 1: first serial bit of a symbol is the word MSB
  localparam bit MSB_FIRST_DFLT = 1'b1;

endpackage

// File: rtl/qam_spc.sv
// Serial-to-parallel converter: packs BPS consecutive enabled Din bits into one
// registered symbol word for the constellation mapper.
module qam_spc
  import qam_spc_pkg::*;
#(
  parameter int BPS       = QPSK_BPS,
  parameter bit MSB_FIRST = MSB_FIRST_DFLT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           Din,
  output logic [BPS-1:0] OUT
);

  localparam int CW = $clog2(BPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BPS - 1);

  logic [CW-1:0]  r_cnt;
  logic [BPS-2:0] r_sr;
  logic [BPS-1:0] w_word;
  logic [BPS-1:0] w_sym;

  // w_word is the symbol in arrival order, first bit at the MSB
  assign w_word = {r_sr, Din};

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sym = w_word;
    end else begin : g_lsb_first
      for (genvar i = 0; i < BPS; i++) begin : g_rev
        assign w_sym[i] = w_word[BPS-1-i];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_sr  <= '0;
      OUT   <= '0;
    end else if (en) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        OUT   <= w_sym;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Low BPS-1 bits of w_word are the shifted register; stale bits after
      // completion are pushed out by the next symbol.
      r_sr <= w_word[BPS-2:0];
    end
  end

endmodule

// File: tb/tb_qam_spc.sv
// Directed self-checking bench for qam_spc: QPSK MSB-first instance plus a
// 4-bit LSB-first instance for the parameter check.
module tb_qam_spc;

  logic       clk;
  logic       rst;
  logic       en;
  logic       en4;
  logic       Din;
  logic [1:0] OUT;
  logic [3:0] OUT4;

  int checks = 0;
  int errors = 0;

  qam_spc #(.BPS(2), .MSB_FIRST(1'b1)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .Din (Din),
    .OUT (OUT)
  );

  qam_spc #(.BPS(4), .MSB_FIRST(1'b0)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .en  (en4),
    .Din (Din),
    .OUT (OUT4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  // Drive one bit into the QPSK instance, return #1 after the sampling edge
  task automatic step(input logic d, input logic e);
    @(negedge clk);
    Din = d;
    en  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic d);
    @(negedge clk);
    Din = d;
    en  = 1'b0;
    en4 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp2;
  logic       first;
  logic       b;
  int         bulk_ok;

  initial begin
    rst = 1'b0; en = 1'b0; en4 = 1'b0; Din = 1'b0;
    exp2 = 2'b00; first = 1'b0; b = 1'b0; bulk_ok = 0;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      Din = 1'($urandom_range(0, 1));
      en  = 1'($urandom_range(0, 1));
      en4 = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("reset_hold", {6'b0, OUT}, 8'h00);
    end
    check("reset_hold4", {4'b0, OUT4}, 8'h00);
    @(negedge clk);
    en = 1'b0; en4 = 1'b0;
    rst = 1'b1;

    // Asynchronous reset between edges
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("pre_async", {6'b0, OUT}, 8'h03);
    #2 rst = 1'b0;
    #1 check("async_reset", {6'b0, OUT}, 8'h00);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;

    // Directed stream
    step(1'b1, 1'b1); check("stream_e1", {6'b0, OUT}, 8'h00);
    step(1'b0, 1'b1); check("stream_e2", {6'b0, OUT}, 8'h02);
    step(1'b0, 1'b1); check("stream_e3", {6'b0, OUT}, 8'h02);
    step(1'b1, 1'b1); check("stream_e4", {6'b0, OUT}, 8'h01);
    step(1'b1, 1'b1); check("stream_e5", {6'b0, OUT}, 8'h01);
    step(1'b1, 1'b1); check("stream_e6", {6'b0, OUT}, 8'h03);
    step(1'b0, 1'b1); check("stream_e7", {6'b0, OUT}, 8'h03);
    step(1'b0, 1'b1); check("stream_e8", {6'b0, OUT}, 8'h00);

    // Bulk random stream, symbol checked at every second edge
    for (int i = 0; i < 1024; i++) begin
      b = 1'($urandom_range(0, 1));
      step(b, 1'b1);
      if (i % 2 == 0) begin
        first = b;
      end else begin
        exp2 = {first, b};
        if (OUT === exp2) bulk_ok++;
        check("bulk_sym", {6'b0, OUT}, {6'b0, exp2});
      end
    end
    check("bulk_count", bulk_ok[7:0], 8'(bulk_ok == 512 ? bulk_ok : 512));

    // en gaps: symbol straddles three disabled cycles, X on Din ignored
    step(1'b1, 1'b1);
    check("gap_first", {6'b0, OUT}, {6'b0, exp2});
    step(1'b0, 1'b0);
    check("gap_hold0", {6'b0, OUT}, {6'b0, exp2});
    step(1'bx, 1'b0);
    check("gap_hold1", {6'b0, OUT}, {6'b0, exp2});
    step(1'b1, 1'b0);
    check("gap_hold2", {6'b0, OUT}, {6'b0, exp2});
    step(1'b1, 1'b1);
    check("gap_done", {6'b0, OUT}, 8'h03);

    // Mid-symbol reset discards the stale bit
    step(1'b1, 1'b1);
    check("mid_partial", {6'b0, OUT}, 8'h03);
    #2 rst = 1'b0;
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    step(1'b0, 1'b1); check("mid_bit0", {6'b0, OUT}, 8'h00);
    step(1'b1, 1'b1); check("mid_sym", {6'b0, OUT}, 8'h01);

    // BPS=4, LSB-first instance
    step4(1'b1); check("bps4_e1", {4'b0, OUT4}, 8'h00);
    step4(1'b1); check("bps4_e2", {4'b0, OUT4}, 8'h00);
    step4(1'b0); check("bps4_e3", {4'b0, OUT4}, 8'h00);
    step4(1'b0); check("bps4_e4", {4'b0, OUT4}, 8'h03);
    check("bps4_qpsk_idle", {6'b0, OUT}, 8'h01);

    @(negedge clk);
    en4 = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
